// File: rtl/sdram_fifo_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sdram_fifo_arbiter_pkg
// Shared configuration for the SDRAM FIFO arbiter slice.
//   `FIFO_WIDTH / `FIFO_DEPTH / `POINTER_WIDTH : async FIFO geometry
//       (defined here only if not already provided by the build).
//   CMD_*        : cmd_type encodings driven to the SDRAM command controller.
//   arb_state_t  : arbiter state encodings.
//   grant_t      : last-grant memory used by the round-robin build.
//   idx_width()  : ring index width, never narrower than one bit.
// ---------------------------------------------------------------------------
`ifndef FIFO_WIDTH
`define FIFO_WIDTH 16
`endif
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 512
`endif
`ifndef POINTER_WIDTH
`define POINTER_WIDTH 10
`endif

package sdram_fifo_arbiter_pkg;

  localparam logic [1:0] CMD_NONE    = 2'd0;
  localparam logic [1:0] CMD_WRITE   = 2'd1;
  localparam logic [1:0] CMD_READ    = 2'd2;
  localparam logic [1:0] CMD_REFRESH = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REF_CMD  = 3'd1,
    ST_REF_WAIT = 3'd2,
    ST_WR_CMD   = 3'd3,
    ST_WR_DATA  = 3'd4,
    ST_RD_CMD   = 3'd5,
    ST_RD_DATA  = 3'd6
  } arb_state_t;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

  // A ring of one burst still needs a one-bit index register.
  function automatic int idx_width(input int num_bursts);
    int w;
    w = $clog2(num_bursts);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/sdram_burst_ring_ptr.sv
// ---------------------------------------------------------------------------
// sdram_burst_ring_ptr
// Burst index for one direction of the SDRAM ring region, plus the word
// address of the burst it points at.
//   clk, rst : SDRAM clock, synchronous active-high reset (index -> 0)
//   adv_i    : advance one burst (wraps NUM_BURSTS-1 -> 0)
//   addr_o   : BASE_ADDR + idx*BURST_LEN, truncated to ADDR_WIDTH
// ---------------------------------------------------------------------------
module sdram_burst_ring_ptr
  import sdram_fifo_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 22,
  parameter int BURST_LEN  = 8,
  parameter int BASE_ADDR  = 0,
  parameter int NUM_BURSTS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  localparam int IDX_W    = idx_width(NUM_BURSTS);
  localparam int BL_SHIFT = $clog2(BURST_LEN);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // Next index: hold, step, or wrap at the end of the region.
  always_comb begin
    idx_d = idx_q;
    if (adv_i) begin
      if (idx_q == IDX_W'(NUM_BURSTS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // BURST_LEN is a power of two, so the multiply is a shift.
  assign addr_o = ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(idx_q) << BL_SHIFT);

endmodule

// File: rtl/sdram_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_fifo_arbiter
// Schedules write bursts (write FIFO -> SDRAM), read bursts (SDRAM -> read
// FIFO) and refreshes toward the SDRAM command controller, keeping a ring
// region in SDRAM with a write index, a read index and a fill count in bursts.
// Optional build macro: ARB_ROUND_ROBIN_EN -- alternate write/read on a tie
// (default build: write always beats read).
// Ports:
//   clk, rst                  SDRAM clock, synchronous active-high reset
//   wr_fifo_count/_empty/_ren write FIFO occupancy, empty flag, read strobe
//   rd_fifo_room/_wen         read FIFO free slots, write strobe
//   rd_enable                 user permits read-back bursts
//   ref_req                   refresh due (level, held until serviced)
//   cmd_req/_type/_addr/_ack  command handshake with the controller
//   wr_data_req, rd_data_vld  per-beat strobes from the controller
//   burst_done                pulse: current command finished
//   fill_bursts, busy         status
// ---------------------------------------------------------------------------
`ifndef POINTER_WIDTH
`define POINTER_WIDTH 10
`endif

module sdram_fifo_arbiter
  import sdram_fifo_arbiter_pkg::*;
#(
  parameter  int ADDR_WIDTH = 22,
  parameter  int BURST_LEN  = 8,
  parameter  int BASE_ADDR  = 0,
  parameter  int NUM_BURSTS = 1024,
  localparam int FILL_W     = $clog2(NUM_BURSTS) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [`POINTER_WIDTH-1:0] wr_fifo_count,
  input  logic                      wr_fifo_empty,
  output logic                      wr_fifo_ren,
  input  logic [`POINTER_WIDTH-1:0] rd_fifo_room,
  output logic                      rd_fifo_wen,
  input  logic                      rd_enable,
  input  logic                      ref_req,
  output logic                      cmd_req,
  output logic [1:0]                cmd_type,
  output logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic                      cmd_ack,
  input  logic                      wr_data_req,
  input  logic                      rd_data_vld,
  input  logic                      burst_done,
  output logic [FILL_W-1:0]         fill_bursts,
  output logic                      busy
);

  localparam int PW     = `POINTER_WIDTH;
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;

  arb_state_t         state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               done_seen_q, done_seen_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
`ifdef ARB_ROUND_ROBIN_EN
  grant_t             last_grant_q, last_grant_d;
`endif

  logic                  wr_ok_s, rd_ok_s, data_done_s;
  logic                  wr_adv_s, rd_adv_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s, rd_addr_s;

  sdram_burst_ring_ptr #(
    .ADDR_WIDTH(ADDR_WIDTH), .BURST_LEN(BURST_LEN),
    .BASE_ADDR(BASE_ADDR),   .NUM_BURSTS(NUM_BURSTS)
  ) u_wr_ptr (
    .clk(clk), .rst(rst), .adv_i(wr_adv_s), .addr_o(wr_addr_s)
  );

  sdram_burst_ring_ptr #(
    .ADDR_WIDTH(ADDR_WIDTH), .BURST_LEN(BURST_LEN),
    .BASE_ADDR(BASE_ADDR),   .NUM_BURSTS(NUM_BURSTS)
  ) u_rd_ptr (
    .clk(clk), .rst(rst), .adv_i(rd_adv_s), .addr_o(rd_addr_s)
  );

  assign wr_ok_s = (wr_fifo_count >= PW'(BURST_LEN)) && !wr_fifo_empty &&
                   (fill_q < FILL_W'(NUM_BURSTS));
  assign rd_ok_s = rd_enable && (fill_q != '0) && (rd_fifo_room >= PW'(BURST_LEN));

  // A burst may retire only after all beats moved and burst_done was seen
  // (latched earlier or arriving this cycle).
  assign data_done_s = (beat_q == BEAT_W'(BURST_LEN)) && (done_seen_q || burst_done);

  // Next-state, bookkeeping and command/strobe outputs.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    done_seen_d = done_seen_q;
    fill_d      = fill_q;
    wr_adv_s    = 1'b0;
    rd_adv_s    = 1'b0;
    wr_fifo_ren = 1'b0;
    rd_fifo_wen = 1'b0;
    cmd_req     = 1'b0;
    cmd_type    = CMD_NONE;
    cmd_addr    = '0;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        beat_d      = '0;
        done_seen_d = 1'b0;
        if (ref_req) begin
          state_d = ST_REF_CMD;
        end else if (wr_ok_s && rd_ok_s) begin
`ifdef ARB_ROUND_ROBIN_EN
          if (last_grant_q == GRANT_READ) begin
            state_d      = ST_WR_CMD;
            last_grant_d = GRANT_WRITE;
          end else begin
            state_d      = ST_RD_CMD;
            last_grant_d = GRANT_READ;
          end
`else
          state_d = ST_WR_CMD;
`endif
        end else if (wr_ok_s) begin
          state_d = ST_WR_CMD;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = GRANT_WRITE;
`endif
        end else if (rd_ok_s) begin
          state_d = ST_RD_CMD;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = GRANT_READ;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REF_CMD: begin
        cmd_req  = 1'b1;
        cmd_type = CMD_REFRESH;
        if (cmd_ack) state_d = ST_REF_WAIT;
        else         state_d = ST_REF_CMD;
      end
      ST_REF_WAIT: begin
        if (burst_done) state_d = ST_IDLE;
        else            state_d = ST_REF_WAIT;
      end
      ST_WR_CMD: begin
        cmd_req  = 1'b1;
        cmd_type = CMD_WRITE;
        cmd_addr = wr_addr_s;
        if (cmd_ack) state_d = ST_WR_DATA;
        else         state_d = ST_WR_CMD;
      end
      ST_WR_DATA: begin
        wr_fifo_ren = wr_data_req && (beat_q < BEAT_W'(BURST_LEN));
        if (wr_fifo_ren) beat_d = beat_q + BEAT_W'(1);
        else             beat_d = beat_q;
        done_seen_d = done_seen_q || burst_done;
        if (data_done_s) begin
          state_d  = ST_IDLE;
          wr_adv_s = 1'b1;
          fill_d   = fill_q + FILL_W'(1);
        end else begin
          state_d = ST_WR_DATA;
        end
      end
      ST_RD_CMD: begin
        cmd_req  = 1'b1;
        cmd_type = CMD_READ;
        cmd_addr = rd_addr_s;
        if (cmd_ack) state_d = ST_RD_DATA;
        else         state_d = ST_RD_CMD;
      end
      ST_RD_DATA: begin
        rd_fifo_wen = rd_data_vld && (beat_q < BEAT_W'(BURST_LEN));
        if (rd_fifo_wen) beat_d = beat_q + BEAT_W'(1);
        else             beat_d = beat_q;
        done_seen_d = done_seen_q || burst_done;
        if (data_done_s) begin
          state_d  = ST_IDLE;
          rd_adv_s = 1'b1;
          fill_d   = fill_q - FILL_W'(1);
        end else begin
          state_d = ST_RD_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      done_seen_q <= 1'b0;
      fill_q      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= GRANT_READ;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      done_seen_q <= done_seen_d;
      fill_q      <= fill_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign fill_bursts = fill_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_fifo_arbiter
// Directed scenarios for sdram_fifo_arbiter with BURST_LEN=8, NUM_BURSTS=4.
// ---------------------------------------------------------------------------
`ifndef POINTER_WIDTH
`define POINTER_WIDTH 10
`endif

module tb_sdram_fifo_arbiter;

  localparam int AW = 22;
  localparam int PW = `POINTER_WIDTH;

  logic          clk;
  logic          rst;
  logic [PW-1:0] wr_fifo_count;
  logic          wr_fifo_empty;
  logic          wr_fifo_ren;
  logic [PW-1:0] rd_fifo_room;
  logic          rd_fifo_wen;
  logic          rd_enable;
  logic          ref_req;
  logic          cmd_req;
  logic [1:0]    cmd_type;
  logic [AW-1:0] cmd_addr;
  logic          cmd_ack;
  logic          wr_data_req;
  logic          rd_data_vld;
  logic          burst_done;
  logic [2:0]    fill_bursts;
  logic          busy;

  int tests_run;
  int tests_failed;

  sdram_fifo_arbiter #(
    .ADDR_WIDTH(AW), .BURST_LEN(8), .BASE_ADDR(0), .NUM_BURSTS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_fifo_count(wr_fifo_count), .wr_fifo_empty(wr_fifo_empty), .wr_fifo_ren(wr_fifo_ren),
    .rd_fifo_room(rd_fifo_room), .rd_fifo_wen(rd_fifo_wen), .rd_enable(rd_enable),
    .ref_req(ref_req), .cmd_req(cmd_req), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
    .cmd_ack(cmd_ack), .wr_data_req(wr_data_req), .rd_data_vld(rd_data_vld),
    .burst_done(burst_done), .fill_bursts(fill_bursts), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wr_fifo_count = '0; wr_fifo_empty = 1'b1; rd_fifo_room = '0;
    rd_enable = 1'b0; ref_req = 1'b0; cmd_ack = 1'b0;
    wr_data_req = 1'b0; rd_data_vld = 1'b0; burst_done = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) until the DUT raises cmd_req.
  task automatic wait_cmd(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Acknowledge the pending command, move 8 beats, then pulse burst_done.
  task automatic run_burst(input bit is_wr);
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (is_wr) wr_data_req = 1'b1;
      else       rd_data_vld = 1'b1;
      tick();
    end
    wr_data_req = 1'b0;
    rd_data_vld = 1'b0;
    burst_done  = 1'b1;
    tick();
    burst_done  = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    wr_fifo_count = 10'd8; wr_fifo_empty = 1'b0; wr_data_req = 1'b1; rd_data_vld = 1'b1;
    rst = 1'b1;
    tick();
    tests_run++;
    if ({cmd_req, cmd_type, cmd_addr, wr_fifo_ren, rd_fifo_wen, fill_bursts, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got req=%b type=%0d addr=%0d ren=%b wen=%b fill=%0d busy=%b, want all 0",
               cmd_req, cmd_type, cmd_addr, wr_fifo_ren, rd_fifo_wen, fill_bursts, busy);
    end
    clear_inputs();
    rst = 1'b0;
    cmd_ack = 1'b1;
    tick();
    tick();
    cmd_ack = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || cmd_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_ack_ignored: got busy=%b req=%b, want 0 0", busy, cmd_req);
    end
  endtask

  task automatic test_write_burst();
    bit seen;
    int ren_cnt;
    apply_reset();
    wr_fifo_count = 10'd8; wr_fifo_empty = 1'b0;
    tick();
    tests_run++;
    if (cmd_req !== 1'b1 || cmd_type !== 2'd1 || cmd_addr !== 22'd0) begin
      tests_failed++;
      $display("FAIL wr_cmd: got req=%b type=%0d addr=%0d, want 1 1 0", cmd_req, cmd_type, cmd_addr);
    end
    wr_fifo_count = '0; wr_fifo_empty = 1'b1;
    wr_data_req = 1'b1;
    tick();
    tick();
    tests_run++;
    if (cmd_req !== 1'b1 || cmd_type !== 2'd1 || cmd_addr !== 22'd0 || wr_fifo_ren !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_cmd_hold: got req=%b type=%0d addr=%0d ren=%b, want 1 1 0 0",
               cmd_req, cmd_type, cmd_addr, wr_fifo_ren);
    end
    wr_data_req = 1'b0;
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    ren_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      wr_data_req = 1'b1;
      #1;
      if (wr_fifo_ren === 1'b1) ren_cnt++;
      tick();
    end
    wr_data_req = 1'b0;
    tests_run++;
    if (ren_cnt != 8) begin
      tests_failed++;
      $display("FAIL wr_ren_count: got %0d, want 8", ren_cnt);
    end
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    tests_run++;
    if (fill_bursts !== 3'd1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_complete: got fill=%0d busy=%b, want 1 0", fill_bursts, busy);
    end
    wr_fifo_count = 10'd8; wr_fifo_empty = 1'b0;
    wait_cmd(seen);
    tests_run++;
    if (!seen || cmd_type !== 2'd1 || cmd_addr !== 22'd8) begin
      tests_failed++;
      $display("FAIL wr_next_addr: got seen=%b type=%0d addr=%0d, want 1 1 8", seen, cmd_type, cmd_addr);
    end
  endtask

  task automatic test_refresh_priority();
    bit seen;
    apply_reset();
    ref_req = 1'b1; wr_fifo_count = 10'd8; wr_fifo_empty = 1'b0;
    tick();
    tests_run++;
    if (cmd_req !== 1'b1 || cmd_type !== 2'd3 || cmd_addr !== 22'd0) begin
      tests_failed++;
      $display("FAIL ref_first: got req=%b type=%0d addr=%0d, want 1 3 0", cmd_req, cmd_type, cmd_addr);
    end
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0; ref_req = 1'b0;
    wr_data_req = 1'b1; rd_data_vld = 1'b1;
    tick();
    tests_run++;
    if (wr_fifo_ren !== 1'b0 || rd_fifo_wen !== 1'b0 || busy !== 1'b1 || cmd_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL ref_wait_quiet: got ren=%b wen=%b busy=%b req=%b, want 0 0 1 0",
               wr_fifo_ren, rd_fifo_wen, busy, cmd_req);
    end
    wr_data_req = 1'b0; rd_data_vld = 1'b0;
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    wait_cmd(seen);
    tests_run++;
    if (!seen || cmd_type !== 2'd1 || cmd_addr !== 22'd0 || fill_bursts !== 3'd0) begin
      tests_failed++;
      $display("FAIL ref_then_wr: got seen=%b type=%0d addr=%0d fill=%0d, want 1 1 0 0",
               seen, cmd_type, cmd_addr, fill_bursts);
    end
  endtask

  task automatic test_full_region();
    bit seen;
    int bad;
    apply_reset();
    wr_fifo_count = 10'd16; wr_fifo_empty = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      wait_cmd(seen);
      if (!seen || cmd_type !== 2'd1 || cmd_addr !== 22'(i * 8)) bad++;
      run_burst(1'b1);
    end
    tests_run++;
    if (bad != 0 || fill_bursts !== 3'd4) begin
      tests_failed++;
      $display("FAIL full_fill: got bad_cmds=%0d fill=%0d, want 0 4", bad, fill_bursts);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cmd_req !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL full_no_write: got %0d busy cycles, want 0", bad);
    end
    rd_enable = 1'b1; rd_fifo_room = 10'd8;
    wait_cmd(seen);
    tests_run++;
    if (!seen || cmd_type !== 2'd2 || cmd_addr !== 22'd0) begin
      tests_failed++;
      $display("FAIL full_read: got seen=%b type=%0d addr=%0d, want 1 2 0", seen, cmd_type, cmd_addr);
    end
    rd_enable = 1'b0;
    run_burst(1'b0);
    tests_run++;
    if (fill_bursts !== 3'd3) begin
      tests_failed++;
      $display("FAIL full_drain: got fill=%0d, want 3", fill_bursts);
    end
    wait_cmd(seen);
    tests_run++;
    if (!seen || cmd_type !== 2'd1 || cmd_addr !== 22'd0) begin
      tests_failed++;
      $display("FAIL ring_wrap: got seen=%b type=%0d addr=%0d, want 1 1 0", seen, cmd_type, cmd_addr);
    end
  endtask

  task automatic test_read_gating();
    bit seen;
    int bad;
    int wen_cnt;
    apply_reset();
    wr_fifo_count = 10'd8; wr_fifo_empty = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_cmd(seen);
      if (i == 1) begin
        wr_fifo_count = '0; wr_fifo_empty = 1'b1;
      end
      run_burst(1'b1);
    end
    rd_enable = 1'b1; rd_fifo_room = 10'd7;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cmd_req !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0 || fill_bursts !== 3'd2) begin
      tests_failed++;
      $display("FAIL rd_room_gate: got req_cycles=%0d fill=%0d, want 0 2", bad, fill_bursts);
    end
    rd_fifo_room = 10'd8;
    wait_cmd(seen);
    tests_run++;
    if (!seen || cmd_type !== 2'd2 || cmd_addr !== 22'd0) begin
      tests_failed++;
      $display("FAIL rd_cmd: got seen=%b type=%0d addr=%0d, want 1 2 0", seen, cmd_type, cmd_addr);
    end
    rd_enable = 1'b0;
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    wen_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      rd_data_vld = 1'b1;
      #1;
      if (rd_fifo_wen === 1'b1) wen_cnt++;
      tick();
    end
    rd_data_vld = 1'b0;
    tests_run++;
    if (wen_cnt != 8) begin
      tests_failed++;
      $display("FAIL rd_wen_count: got %0d, want 8", wen_cnt);
    end
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    tests_run++;
    if (fill_bursts !== 3'd1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_complete: got fill=%0d busy=%b, want 1 0", fill_bursts, busy);
    end
  endtask

  task automatic test_tie();
    bit seen;
    logic [1:0] exp_seq [5];
    logic [1:0] got;
    int bad;
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd1; exp_seq[3] = 2'd2; exp_seq[4] = 2'd1;
`else
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd1; exp_seq[2] = 2'd1; exp_seq[3] = 2'd1; exp_seq[4] = 2'd2;
`endif
    apply_reset();
    wr_fifo_count = 10'd16; wr_fifo_empty = 1'b0;
    rd_enable = 1'b1; rd_fifo_room = 10'd8;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      wait_cmd(seen);
      got = cmd_type;
      if (!seen || got !== exp_seq[i]) begin
        bad++;
        $display("FAIL tie_seq[%0d]: got seen=%b type=%0d, want type %0d", i, seen, got, exp_seq[i]);
      end
      run_burst(got == 2'd1);
    end
    tests_run++;
    if (bad != 0) tests_failed++;
  endtask

  task automatic test_reset_mid_burst();
    bit seen;
    apply_reset();
    wr_fifo_count = 10'd8; wr_fifo_empty = 1'b0;
    wait_cmd(seen);
    run_burst(1'b1);
    wait_cmd(seen);
    tests_run++;
    if (!seen || cmd_addr !== 22'd8 || fill_bursts !== 3'd1) begin
      tests_failed++;
      $display("FAIL pre_reset_cmd: got seen=%b addr=%0d fill=%0d, want 1 8 1", seen, cmd_addr, fill_bursts);
    end
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_data_req = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if ({cmd_req, cmd_type, cmd_addr, wr_fifo_ren, rd_fifo_wen, fill_bursts, busy} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset: got req=%b type=%0d addr=%0d ren=%b wen=%b fill=%0d busy=%b, want all 0",
               cmd_req, cmd_type, cmd_addr, wr_fifo_ren, rd_fifo_wen, fill_bursts, busy);
    end
    rst = 1'b0;
    wr_data_req = 1'b0;
    wait_cmd(seen);
    tests_run++;
    if (!seen || cmd_type !== 2'd1 || cmd_addr !== 22'd0) begin
      tests_failed++;
      $display("FAIL post_reset_idx: got seen=%b type=%0d addr=%0d, want 1 1 0", seen, cmd_type, cmd_addr);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_write_burst();
    test_refresh_priority();
    test_full_region();
    test_read_gating();
    test_tie();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
